// File: rtl/toeplitz_p_extractor.sv
// Streaming GF(2) Toeplitz extractor with a bit-serial output stage.
// Define TOEPLITZ_DEBUG_EN for a simulation-only trace of every result frame.

module toeplitz_p #(
  parameter int BS    = 64,
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 2,
  localparam int SW   = N + L - 1,
  parameter logic [SW-1:0] SEED = SW'({((SW + 1) / 2){2'b01}})
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [L-1:0]     q,
  output logic             qstrobe
);

  localparam int WORDS = N / WIDTH;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  acc_q, acc_d;
  logic [L-1:0]  q_q, q_d;
  logic [SW-1:0] gen_q, gen_d;
  logic          qstrobe_q, qstrobe_d;
  logic [L-1:0]  contrib_s;
  logic          last_s;

  // Result bit p (row L-1-p) sees column j through gen bit SW-1-p-w once gen is shifted by k*WIDTH.
  for (genvar b = 0; b < L / BS; b++) begin : g_lane
    logic [BS-1:0] lane_s;
    always_comb begin
      lane_s = '0;
      for (int w = 0; w < WIDTH; w++) begin
        for (int e = 0; e < BS; e++) begin
          lane_s[e] = lane_s[e] ^ (data[WIDTH-1-w] & gen_q[SW-1-(b*BS+e)-w]);
        end
      end
    end
    assign contrib_s[b*BS +: BS] = lane_s;
  end

  assign last_s = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    gen_d     = gen_q;
    q_d       = q_q;
    qstrobe_d = 1'b0;
    if (last_s) begin
      cnt_d     = '0;
      acc_d     = '0;
      gen_d     = SEED;
      q_d       = acc_q ^ contrib_s;
      qstrobe_d = 1'b1;
    end else begin
      cnt_d     = cnt_q + CW'(1);
      acc_d     = acc_q ^ contrib_s;
      gen_d     = gen_q << WIDTH;
      q_d       = q_q;
      qstrobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      gen_q     <= SEED;
      q_q       <= '0;
      qstrobe_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      gen_q     <= gen_d;
      q_q       <= q_d;
      qstrobe_q <= qstrobe_d;
    end
  end

  assign q       = q_q;
  assign qstrobe = qstrobe_q;

`ifdef TOEPLITZ_DEBUG_EN
`ifndef SYNTHESIS
  int unsigned frame_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 0;
    end else if (qstrobe_q) begin
      frame_cnt_q <= frame_cnt_q + 1;
      $display("%0t toeplitz frame %0d q=%b", $time, frame_cnt_q, q_q);
    end
  end
`endif
`else
  // trace disabled
`endif

endmodule

module serializer #(
  parameter int L = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [L-1:0] q,
  input  logic         qstrobe,
  output logic         qbit,
  output logic         qbiten
);

  localparam int RW = $clog2(L + 1);

  logic [L-1:0]  sh_q, sh_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          qbit_q, qbit_d;
  logic          qbiten_q, qbiten_d;

  // A strobe always wins so that a new word restarts the burst immediately.
  always_comb begin
    sh_d     = sh_q;
    rem_d    = rem_q;
    qbit_d   = 1'b0;
    qbiten_d = 1'b0;
    if (qstrobe) begin
      qbit_d   = q[L-1];
      qbiten_d = 1'b1;
      sh_d     = q << 1;
      rem_d    = RW'(L - 1);
    end else if (rem_q != '0) begin
      qbit_d   = sh_q[L-1];
      qbiten_d = 1'b1;
      sh_d     = sh_q << 1;
      rem_d    = rem_q - RW'(1);
    end else begin
      qbit_d   = 1'b0;
      qbiten_d = 1'b0;
      sh_d     = sh_q;
      rem_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q     <= '0;
      rem_q    <= '0;
      qbit_q   <= 1'b0;
      qbiten_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      qbit_q   <= qbit_d;
      qbiten_q <= qbiten_d;
    end
  end

  assign qbit   = qbit_q;
  assign qbiten = qbiten_q;

endmodule

module toeplitz_p_extractor #(
  parameter int BS    = 64,
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 2,
  localparam int SW   = N + L - 1,
  parameter logic [SW-1:0] SEED = SW'({((SW + 1) / 2){2'b01}})
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [L-1:0]     q_o,
  output logic             qstrobe_o,
  output logic             qbit_o,
  output logic             qbiten_o
);

  logic [L-1:0] q_s;
  logic         qstrobe_s;

  toeplitz_p #(
    .BS(BS), .N(N), .L(L), .WIDTH(WIDTH), .SEED(SEED)
  ) u_toeplitz (
    .clk(clk_i), .reset(rst_i), .data(data_i), .q(q_s), .qstrobe(qstrobe_s)
  );

  serializer #(
    .L(L)
  ) u_ser (
    .clk(clk_i), .reset(rst_i), .q(q_s), .qstrobe(qstrobe_s),
    .qbit(qbit_o), .qbiten(qbiten_o)
  );

  assign q_o       = q_s;
  assign qstrobe_o = qstrobe_s;

endmodule

// File: tb/tb_toeplitz_p_extractor.sv
// Directed bench: extractor results against a direct row-by-column GF(2) model,
// plus serial output of the top and of a standalone serializer.
module tb_toeplitz_p_extractor;

  localparam logic [383:0] SEED_FULL = {
    64'h9E37_79B9_7F4A_7C15, 64'hBF58_476D_1CE4_E5B9,
    64'h94D0_49BB_1331_11EB, 64'hD6E8_FEB8_6659_FD93,
    64'hA076_1D64_78BD_642F, 64'hE703_7ED1_A0B4_28DB};
  localparam logic [382:0] SEED_TB = SEED_FULL[382:0];

  localparam logic [255:0] FR0 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0};
  localparam logic [255:0] FR1 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                  64'hAAAA_5555_AAAA_5555, 64'h8000_0000_0000_0001};
  localparam logic [255:0] FR2 = {64'h5A5A_A5A5_3C3C_C3C3, 64'h0F0F_F0F0_1234_5678,
                                  64'h8765_4321_0FED_CBA9, 64'h7777_8888_9999_6666};
  localparam logic [255:0] FR3 = {64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
                                  64'hC001_D00D_BEEF_FACE, 64'h0BAD_F00D_DEAD_C0DE};

  logic         clk;
  logic         rst;
  logic [1:0]   data_i;
  logic [127:0] q_o;
  logic         qstrobe_o;
  logic         qbit_o;
  logic         qbiten_o;

  logic [127:0] sq;
  logic         sstb;
  logic         sbit;
  logic         sben;

  int           errs;
  int           checks;
  logic [127:0] last_q;
  logic [127:0] ser_exp;
  int           ser_idx;

  toeplitz_p_extractor #(
    .BS(64), .N(256), .L(128), .WIDTH(2), .SEED(SEED_TB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .q_o(q_o),
    .qstrobe_o(qstrobe_o), .qbit_o(qbit_o), .qbiten_o(qbiten_o)
  );

  serializer #(.L(128)) u_ser_alone (
    .clk(clk), .reset(rst), .q(sq), .qstrobe(sstb), .qbit(sbit), .qbiten(sben)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [255:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      for (int j = 0; j < 256; j++) begin
        if (x[j]) r[127-i] = r[127-i] ^ SEED_TB[255+i-j];
      end
    end
    return r;
  endfunction

  task automatic check_cycle(input logic exp_stb, input logic [127:0] exp_q, input logic chk_hold);
    if (ser_idx > 0) begin
      check_val("ser_en", {127'd0, qbiten_o}, 128'd1);
      check_val("ser_bit", {127'd0, qbit_o}, {127'd0, ser_exp[ser_idx-1]});
      ser_idx--;
    end else begin
      check_val("ser_idle_en", {127'd0, qbiten_o}, 128'd0);
      check_val("ser_idle_bit", {127'd0, qbit_o}, 128'd0);
    end
    check_val("qstrobe", {127'd0, qstrobe_o}, {127'd0, exp_stb});
    if (exp_stb) begin
      check_val("q", q_o, exp_q);
      last_q  = exp_q;
      ser_exp = exp_q;
      ser_idx = 128;
    end else if (chk_hold) begin
      check_val("q_hold", q_o, last_q);
    end
  endtask

  task automatic run_frame(input logic [255:0] x, input logic [127:0] exp, input int nwords);
    for (int k = 0; k < nwords; k++) begin
      data_i = {x[2*k], x[2*k+1]};
      @(negedge clk);
      check_cycle(k == 127, exp, k == 64);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_q", q_o, 128'd0);
    check_val("rst_qstrobe", {127'd0, qstrobe_o}, 128'd0);
    check_val("rst_qbiten", {127'd0, qbiten_o}, 128'd0);
    check_val("rst_qbit", {127'd0, qbit_o}, 128'd0);
  endtask

  initial begin
    logic [255:0] one_x;
    logic [127:0] one_exp;
    logic [127:0] q1;
    logic [127:0] q2;
    errs    = 0;
    checks  = 0;
    last_q  = '0;
    ser_exp = '0;
    ser_idx = 0;
    rst     = 1'b1;
    data_i  = 2'b00;
    sq      = '0;
    sstb    = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state();
    check_val("rst_ser_alone_en", {127'd0, sben}, 128'd0);
    rst = 1'b0;

    run_frame(256'd0, 128'd0, 128);

    one_x = 256'd1;
    for (int i = 0; i < 128; i++) one_exp[127-i] = SEED_TB[255+i];
    run_frame(one_x, one_exp, 128);

    run_frame(FR0, model(FR0), 128);
    run_frame(FR1, model(FR1), 128);
    run_frame(FR2, model(FR2), 128);
    run_frame(FR3, model(FR3), 128);

    // 40 words of a frame that the reset must throw away, mid serial burst
    run_frame(FR1, 128'd0, 40);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    last_q  = '0;
    ser_idx = 0;
    rst     = 1'b0;
    run_frame(FR2, model(FR2), 128);
    run_frame(256'd0, 128'd0, 128);

    // standalone serializer: single burst with MSB and LSB set
    data_i = 2'b00;
    sq     = {1'b1, 126'd0, 1'b1};
    sstb   = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      sstb = 1'b0;
      check_val("sa_en", {127'd0, sben}, 128'd1);
      check_val("sa_bit", {127'd0, sbit}, {127'd0, (i == 0 || i == 127)});
    end
    @(negedge clk);
    check_val("sa_idle_en", {127'd0, sben}, 128'd0);
    check_val("sa_idle_bit", {127'd0, sbit}, 128'd0);

    // standalone serializer: restart 64 bits into a burst
    q1   = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    q2   = 128'hF00D_CAFE_1234_5678_9ABC_DEF0_8888_1111;
    sq   = q1;
    sstb = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      sstb = 1'b0;
      check_val("sb_en1", {127'd0, sben}, 128'd1);
      check_val("sb_bit1", {127'd0, sbit}, {127'd0, q1[127-i]});
    end
    sq   = q2;
    sstb = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      sstb = 1'b0;
      check_val("sb_en2", {127'd0, sben}, 128'd1);
      check_val("sb_bit2", {127'd0, sbit}, {127'd0, q2[127-i]});
    end
    @(negedge clk);
    check_val("sb_idle_en", {127'd0, sben}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/toeplitz_p_extractor.md
# toeplitz_p_extractor

Streaming Toeplitz randomness extractor with bit-serial output stage. Module `toeplitz_p` accepts raw bits WIDTH per clock, multiplies each N-bit input frame by a fixed L×N Toeplitz matrix over GF(2), and presents the L-bit result with a one-cycle strobe. Companion module `serializer` converts each result into a bit stream. Both sit between the entropy-source sampler and the downstream output link.

## Interface
`toeplitz_p` parameters:
- BS, 64, parallel block size; N and L are multiples of BS; BS is a multiple of WIDTH
- N, 256, input frame length in bits
- L, 128, output length in bits (L < N)
- WIDTH, 2, input bits per clock; N is a multiple of WIDTH
- SEED, N+L-1 bits, default all bits = repeating `0101` pattern (LSB = 1), Toeplitz generator

`toeplitz_p` ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- data  in  WIDTH  input word, MSB = earliest bit
- q  out  L  extractor result
- qstrobe  out  1  one-cycle pulse: new q valid

`serializer` parameter: L, 128, word length. Ports: clk in 1; reset in 1 (async, active-high); q in L; qstrobe in 1; qbit out 1 serial data; qbiten out 1 serial data valid.

## Operation
- Input bit index j = 0..N-1 in arrival order; word k carries j = k·WIDTH .. k·WIDTH+WIDTH-1, data[WIDTH-1] = lowest j.
- Matrix: T[i][j] = SEED[N-1+i-j], i = 0..L-1.
- Row i result r_i = XOR over j of T[i][j]·x_j; q[L-1-i] = r_i (row 0 is q MSB).
- Implementation: L-bit accumulator in L/BS lanes of BS bits; per cycle XOR in WIDTH matrix columns selected by incoming bits; column generator is a shift register over SEED advanced WIDTH positions per cycle.
- Word counter 0..N/WIDTH-1, wraps; frames are back-to-back, no gaps, every post-reset cycle consumes one word.
- On last word of a frame: q ← final result (accumulator including that word), qstrobe = 1; accumulator and column generator restart for next frame in same cycle.
- q holds until next frame end.
- serializer: on qstrobe, load q; emit MSB first, one bit per cycle, qbiten = 1 for exactly L cycles. qstrobe during an active burst reloads and restarts (takes priority).

## Timing
- Reset: q = 0, qstrobe = 0, counter = 0, accumulator = 0, generator = initial SEED alignment; qbit = 0, qbiten = 0.
- First rising edge with reset low samples word 0.
- qstrobe high for the cycle following the edge that samples word N/WIDTH-1; latency N/WIDTH cycles from word 0 edge to q update; period N/WIDTH cycles.
- serializer: first qbit/qbiten on the cycle following qstrobe sample; last bit L cycles later; qbiten low when idle, qbit = 0 when idle.
- Reset mid-frame: partial frame discarded; next word after release is word 0; no qstrobe for the discarded frame; serializer burst aborted.

## Configuration
- TOEPLITZ_DEBUG_EN defined: at each qstrobe, simulation-only `$display` of time, frame count, and q in binary; excluded from synthesis.
- Undefined: no display; functional behaviour identical.

## Test plan
- Zero input frame (data = 0 for 128 cycles) -> qstrobe after 128th word, q = 0.
- Single 1 at j = 0 (first word = 2'b10, rest 0) -> q[L-1-i] = SEED[N-1+i] for all i.
- Four reference frames (SEED from reference generator, 64-bit hex vectors) back-to-back -> four qstrobe pulses 128 cycles apart, q equal to precomputed 128-bit results each time.
- Reset asserted at word 40, released -> counter restarts; first qstrobe 128 cycles after release, result of post-reset frame only.
- Serializer with q = 128'h8000...0001 -> qbiten high 128 cycles, qbit = 1 on first and last cycle, 0 otherwise.
- Serializer restart: second qstrobe 64 cycles into burst -> burst restarts with new MSB, qbiten stays high continuously.
